// File: rtl/dp_ram_fifo_pkg.sv
// dp_ram_fifo_pkg
//   Shared constants for the show-ahead FIFO and its block RAM.
//   FIFO_ADDR_DEFAULT : default address width (capacity = 2**ADDR words)
//   FIFO_DATA_DEFAULT : default word width in bits
package dp_ram_fifo_pkg;
  localparam int FIFO_ADDR_DEFAULT = 10;
  localparam int FIFO_DATA_DEFAULT = 16;
endpackage

// File: rtl/dp_ram.sv
// dp_ram
//   Dual-port block RAM, synchronous read, no reset on contents or read data.
//   Port A: write-only (a_wr, a_addr, a_din), clocked by a_clk.
//   Port B: read/write (b_wr, b_addr, b_din), registered read data on b_dout,
//           clocked by b_clk. Reads return the pre-write contents (read-first).
//   Ports
//     a_clk, a_wr, a_addr[ADDR], a_din[DATA]
//     b_clk, b_wr, b_addr[ADDR], b_din[DATA], b_dout[DATA]
module dp_ram
  import dp_ram_fifo_pkg::*;
#(
  parameter int DATA = FIFO_DATA_DEFAULT,
  parameter int ADDR = FIFO_ADDR_DEFAULT
) (
  input  logic            a_clk,
  input  logic            a_wr,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  input  logic            b_clk,
  input  logic            b_wr,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout
);

  logic [DATA-1:0] mem [2**ADDR];

  // Both write ports update the array from one process so the storage has a
  // single driver; this requires b_clk to be the same clock as a_clk.
  // On a same-address collision port B's word wins.
  always_ff @(posedge a_clk) begin
    if (a_wr) mem[a_addr] <= a_din;
    if (b_wr) mem[b_addr] <= b_din;
  end

  always_ff @(posedge b_clk) begin
    b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/dp_ram_fifo.sv
// dp_ram_fifo
//   Single-clock show-ahead FIFO on top of dp_ram. The head word is presented
//   on rd_data with no read latency; rd_en acknowledges it.
//   Handshake: a push happens on an edge where wr_en=1 and full=0; a pop
//   happens on an edge where rd_en=1 and empty=0. Requests against a full or
//   empty FIFO are dropped and flagged one cycle later on overflow/underflow.
//   Ports
//     clk, rst_n (async, active low)
//     wr_en, wr_data[DATA], full, almost_full     (producer side)
//     rd_en, rd_data[DATA], empty                 (consumer side)
//     count[ADDR+1], overflow, underflow          (status)
module dp_ram_fifo
  import dp_ram_fifo_pkg::*;
#(
  parameter int DATA  = FIFO_DATA_DEFAULT,
  parameter int ADDR  = FIFO_ADDR_DEFAULT,
  parameter int AFULL = (2**ADDR) - 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  output logic            full,
  output logic            almost_full,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            empty,
  output logic [ADDR:0]   count,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [ADDR:0] DEPTH     = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AFULL_LVL = (ADDR+1)'(AFULL);

  logic [ADDR:0] wptr;
  logic [ADDR:0] rptr;
  logic [ADDR:0] wptr_d1;
  logic [ADDR:0] rptr_next;
  logic          push;
  logic          pop;

  assign count       = wptr - rptr;
  assign full        = (count == DEPTH);
  assign almost_full = (count >= AFULL_LVL);
  // Compared against the one-cycle-old write pointer: a freshly written word
  // only reaches b_dout on the edge after its write.
  assign empty       = (wptr_d1 == rptr);

  assign push      = wr_en & ~full;
  assign pop       = rd_en & ~empty;
  // Read address looks one word ahead on a pop so the next head is already
  // on b_dout after the edge.
  assign rptr_next = rptr + {{ADDR{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      wptr_d1   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + {{ADDR{1'b0}}, push};
      rptr      <= rptr_next;
      wptr_d1   <= wptr;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  dp_ram #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_ram (
    .a_clk  (clk),
    .a_wr   (push),
    .a_addr (wptr[ADDR-1:0]),
    .a_din  (wr_data),
    .b_clk  (clk),
    .b_wr   (1'b0),
    .b_addr (rptr_next[ADDR-1:0]),
    .b_din  ({DATA{1'b0}}),
    .b_dout (rd_data)
  );

endmodule

// File: tb/tb_dp_ram_fifo.sv
// tb_dp_ram_fifo
//   Bench for dp_ram_fifo with ADDR=4 (16 words), DATA=16, AFULL=12.
module tb_dp_ram_fifo;

  localparam int DATA  = 16;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [DATA-1:0] wr_data = '0;
  logic            rd_en = 1'b0;
  logic            full, almost_full, empty, overflow, underflow;
  logic [DATA-1:0] rd_data;
  logic [ADDR:0]   count;

  always #5 clk = ~clk;

  dp_ram_fifo #(.DATA(DATA), .ADDR(ADDR), .AFULL(AFULL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // ---------------- reference model ----------------
  // Occupancy is a queue of words; each word carries the edge number it was
  // pushed on. A word becomes visible one edge after its push.
  logic [DATA-1:0] exp_q[$];
  int              tag_q[$];
  int              edge_cnt = 0;
  logic            m_ovf = 1'b0;
  logic            m_udf = 1'b0;

  int checks = 0;
  int passed = 0;

  function automatic logic m_empty();
    return (exp_q.size() == 0) || (tag_q[0] == edge_cnt);
  endfunction

  function automatic logic m_full();
    return exp_q.size() == DEPTH;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    tag_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [DATA-1:0] din, input logic rd);
    logic was_full, was_empty;
    was_full  = m_full();
    was_empty = m_empty();
    edge_cnt++;
    m_ovf = wr & was_full;
    m_udf = rd & was_empty;
    if (rd && !was_empty) begin
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
    if (wr && !was_full) begin
      exp_q.push_back(din);
      tag_q.push_back(edge_cnt);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic check_model();
    chk("m_empty",     32'(empty),       32'(m_empty()));
    chk("m_count",     32'(count),       32'(exp_q.size()));
    chk("m_full",      32'(full),        32'(m_full()));
    chk("m_afull",     32'(almost_full), 32'(exp_q.size() >= AFULL));
    chk("m_overflow",  32'(overflow),    32'(m_ovf));
    chk("m_underflow", 32'(underflow),   32'(m_udf));
    if (!m_empty()) chk("m_rd_data", 32'(rd_data), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive, take one rising edge, sample on the next negedge.
  task automatic step(input logic wr, input logic [DATA-1:0] din, input logic rd);
    wr_en   = wr;
    wr_data = din;
    rd_en   = rd;
    @(posedge clk);
    model_edge(wr, din, rd);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            wr;
    logic [DATA-1:0] din;
    logic            rd;
    logic            e_empty;
    logic [ADDR:0]   e_count;
    logic            e_full;
    logic            e_ovf;
    logic            e_udf;
    logic            chk_data;
    logic [DATA-1:0] e_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int pw, pr;
    logic [DATA-1:0] d;

    // push 0x1234, show-ahead latency, then count==1 push+pop, drain, underflow
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    vecs[2] = '{1'b1, 16'hABCD, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};

    // reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full",  32'(full),  32'd0);

    // table-driven: single push latency and count==1 simultaneous push/pop
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd);
      chk($sformatf("vec%0d_empty", i), 32'(empty),     32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_count", i), 32'(count),     32'(vecs[i].e_count));
      chk($sformatf("vec%0d_full", i),  32'(full),      32'(vecs[i].e_full));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow),  32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_udf", i),   32'(underflow), 32'(vecs[i].e_udf));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
    end

    // fill 16, overflow on 17th
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 16'(i), 1'b0);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= AFULL));
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 16'hFFFF, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    step(1'b0, 16'h0000, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("ovf_head",  32'(rd_data),  32'd0);

    // full with simultaneous push+pop: push dropped, pop proceeds
    step(1'b1, 16'h5555, 1'b1);
    chk("fullpp_count", 32'(count),    32'd15);
    chk("fullpp_ovf",   32'(overflow), 32'd1);
    chk("fullpp_head",  32'(rd_data),  32'd1);

    // drain 1..15 one per cycle, then underflow
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_data", 32'(rd_data), 32'(i));
      step(1'b0, 16'h0000, 1'b1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    step(1'b0, 16'h0000, 1'b1);
    chk("udf_pulse", 32'(underflow), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    chk("udf_clear", 32'(underflow), 32'd0);

    // continuous push+pop across index wrap at constant occupancy
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 16'(16'h0200 + k), 1'b1);
      chk("stream_count", 32'(count), 32'd3);
      chk("stream_empty", 32'(empty), 32'd0);
    end

    // async reset mid-burst with count 7
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h0700 + i), 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h0777, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd7);
    step(1'b0, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count),     32'd0);
    chk("async_empty", 32'(empty),     32'd1);
    chk("async_full",  32'(full),      32'd0);
    chk("async_ovf",   32'(overflow),  32'd0);
    chk("async_udf",   32'(underflow), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("post_rst_data", 32'(rd_data), 32'h0000BEEF);

    // randomized traffic in phases biased toward full, empty and balanced
    do_reset();
    for (int c = 0; c < 600; c++) begin
      case ((c / 60) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      d = 16'($urandom);
      step($urandom_range(99, 0) < 32'(pw), d, $urandom_range(99, 0) < 32'(pr));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
